hwpe_ctrl_regfile_ctx: RTL



---
 rtl/hwpe_ctrl_regfile_ctx.sv | 94 +++++++++
 1 files changed

// File: rtl/hwpe_ctrl_regfile_ctx.sv
// Multi-context register file for HWPE control slaves: software fills the write
// context while the engine reads the running one; contexts rotate in FIFO order.
module hwpe_ctrl_regfile_ctx #(
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_BYTE    = DATA_WIDTH / 8,
    parameter int unsigned NB_CONTEXT  = 2,
    parameter int unsigned NB_RD_PORTS = 2,
    localparam int unsigned NUM_WORDS  = 2 ** ADDR_WIDTH,
    localparam int unsigned CTX_W      = $clog2(NB_CONTEXT)
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       clear,
    input  logic                                       wr_en,
    input  logic [ADDR_WIDTH-1:0]                      wr_addr,
    input  logic [NUM_BYTE*8-1:0]                      wr_data,
    input  logic [NUM_BYTE-1:0]                        wr_be,
    input  logic                                       commit,
    output logic                                       commit_ready,
    input  logic                                       job_done,
    output logic                                       running_valid,
    output logic [CTX_W-1:0]                           wr_ctx_id,
    output logic [CTX_W-1:0]                           run_ctx_id,
    output logic [CTX_W:0]                             nb_pending,
    input  logic [NB_RD_PORTS-1:0]                     rd_en,
    input  logic [NB_RD_PORTS-1:0][ADDR_WIDTH-1:0]     rd_addr,
    output logic [NB_RD_PORTS-1:0][DATA_WIDTH-1:0]     rd_data,
    output logic [NB_RD_PORTS-1:0]                     rd_valid,
    output logic [NUM_WORDS-1:0][DATA_WIDTH-1:0]       mem_content
);

    localparam logic [CTX_W:0] FULL = (CTX_W+1)'(NB_CONTEXT);

    logic [NB_CONTEXT-1:0][NUM_WORDS-1:0][DATA_WIDTH-1:0] mem;
    logic commit_acc;
    logic done_acc;

    // Status is derived from the registered count, so a commit in the same
    // cycle as a job_done on a full file is still rejected.
    assign commit_ready  = (nb_pending < FULL);
    assign running_valid = (nb_pending != '0);
    assign commit_acc    = commit & commit_ready;
    assign done_acc      = job_done & running_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ctx_id  <= '0;
            run_ctx_id <= '0;
            nb_pending <= '0;
        end else if (clear) begin
            wr_ctx_id  <= '0;
            run_ctx_id <= '0;
            nb_pending <= '0;
        end else begin
            if (commit_acc) wr_ctx_id  <= wr_ctx_id + 1'b1;
            if (done_acc)   run_ctx_id <= run_ctx_id + 1'b1;
            if (commit_acc && !done_acc)      nb_pending <= nb_pending + 1'b1;
            else if (!commit_acc && done_acc) nb_pending <= nb_pending - 1'b1;
        end
    end

    // Writes land in the pre-commit context; dropped while every context is queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '0;
        end else if (clear) begin
            mem <= '0;
        end else if (wr_en && commit_ready) begin
            for (int j = 0; j < NUM_BYTE; j++) begin
                if (wr_be[j]) mem[wr_ctx_id][wr_addr][j*8 +: 8] <= wr_data[j*8 +: 8];
            end
        end
    end

    assign mem_content = mem[run_ctx_id];

    // Reads sample the storage before this edge's write, giving old-data on collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= '0;
        end else if (clear) begin
            rd_data  <= '0;
            rd_valid <= '0;
        end else begin
            rd_valid <= rd_en;
            for (int p = 0; p < NB_RD_PORTS; p++) begin
                if (rd_en[p]) rd_data[p] <= mem_content[rd_addr[p]];
            end
        end
    end

endmodule
